// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline.
// Contents: address/instruction widths, next-PC source encodings, the HALT
// encoding that stops fetch, and the NOP word used for squashed slots.
package mips_pkg;

  localparam int unsigned NB_ADDR        = 32;
  localparam int unsigned NB_INSTRUCTION = 32;

  localparam logic [NB_INSTRUCTION-1:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [NB_INSTRUCTION-1:0] NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_JR     = 2'b11
  } pc_src_e;

endpackage

// File: rtl/pc_register.sv
// Program counter register with next-PC selection.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset (pc -> 0)
//   load              update pc this edge
//   pc_src            next-PC source (sequential / branch / jump / jump-register)
//   branch_target, jump_target, jr_target   candidate targets, forced word-aligned
//   pc                current program counter
module pc_register
  import mips_pkg::*;
#(
  parameter int unsigned NB_ADDR = mips_pkg::NB_ADDR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  pc_src_e            pc_src,
  input  logic [NB_ADDR-1:0] branch_target,
  input  logic [NB_ADDR-1:0] jump_target,
  input  logic [NB_ADDR-1:0] jr_target,
  output logic [NB_ADDR-1:0] pc
);

  // Clears the byte-offset bits so every target lands on a word boundary.
  localparam logic [NB_ADDR-1:0] ALIGN_MASK = ~NB_ADDR'(3);

  logic [NB_ADDR-1:0] pc_next;

  always_comb begin
    pc_next = pc + NB_ADDR'(4);  // wraps modulo 2^NB_ADDR
    unique case (pc_src)
      PC_SRC_SEQ:    pc_next = pc + NB_ADDR'(4);
      PC_SRC_BRANCH: pc_next = branch_target & ALIGN_MASK;
      PC_SRC_JUMP:   pc_next = jump_target & ALIGN_MASK;
      PC_SRC_JR:     pc_next = jr_target & ALIGN_MASK;
      default:       pc_next = pc + NB_ADDR'(4);
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory read port
// and pairs each returned instruction with its PC+4 and a valid bit.
// Ports:
//   i_clock, i_reset   clock, asynchronous active-high reset
//   i_enable           debug run/step enable; low freezes the stage
//   i_stall            load-use stall from the hazard unit
//   i_pc_src           00 seq, 01 branch, 10 jump, 11 jump-register
//   i_branch_target, i_jump_target, i_jr_target   redirect targets from ID
//   o_imem_read_addr   current PC
//   o_imem_read_en     memory read enable (memory holds its output when low)
//   i_imem_data        registered memory read data, one cycle after the address
//   o_instruction      fetched instruction, NOP when not valid
//   o_pc_plus4         address of o_instruction + 4
//   o_valid            o_instruction is live
//   o_halted           sticky, set once HALT_INSTR has been emitted
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned NB_ADDR        = mips_pkg::NB_ADDR,
  parameter int unsigned NB_INSTRUCTION = mips_pkg::NB_INSTRUCTION,
  parameter logic [NB_INSTRUCTION-1:0] HALT_INSTR = {NB_INSTRUCTION{1'b1}}
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_stall,
  input  logic [1:0]                i_pc_src,
  input  logic [NB_ADDR-1:0]        i_branch_target,
  input  logic [NB_ADDR-1:0]        i_jump_target,
  input  logic [NB_ADDR-1:0]        i_jr_target,
  output logic [NB_ADDR-1:0]        o_imem_read_addr,
  output logic                      o_imem_read_en,
  input  logic [NB_INSTRUCTION-1:0] i_imem_data,
  output logic [NB_INSTRUCTION-1:0] o_instruction,
  output logic [NB_ADDR-1:0]        o_pc_plus4,
  output logic                      o_valid,
  output logic                      o_halted
);

  pc_src_e            pc_src;
  logic [NB_ADDR-1:0] pc;
  logic [NB_ADDR-1:0] inflight_pc;
  logic               inflight_valid;
  logic               halted;
  logic               redirect;
  logic               advance;
  logic               halt_seen;

  assign pc_src   = pc_src_e'(i_pc_src);
  assign redirect = (pc_src != PC_SRC_SEQ);
  // A redirect overrides a stall: the stalled fetch is squashed anyway.
  assign advance  = i_enable & ~halted & (~i_stall | redirect);

  pc_register #(
    .NB_ADDR (NB_ADDR)
  ) u_pc_register (
    .clock         (i_clock),
    .reset         (i_reset),
    .load          (advance),
    .pc_src        (pc_src),
    .branch_target (i_branch_target),
    .jump_target   (i_jump_target),
    .jr_target     (i_jr_target),
    .pc            (pc)
  );

  // inflight_* describes the word the memory is currently presenting.
  // A fetch issued in a redirect cycle is squashed (no delay slot).
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      inflight_pc    <= '0;
      inflight_valid <= 1'b0;
      halted         <= 1'b0;
    end else begin
      if (advance) begin
        inflight_pc    <= pc;
        inflight_valid <= ~redirect;
      end
      if (halt_seen) begin
        halted <= 1'b1;
      end
    end
  end

  // HALT itself is emitted once as valid; only a live HALT stops fetch.
  assign o_valid          = inflight_valid & ~halted;
  assign halt_seen        = o_valid & (i_imem_data == HALT_INSTR);
  assign o_instruction    = o_valid ? i_imem_data : NB_INSTRUCTION'(NOP);
  assign o_pc_plus4       = inflight_pc + NB_ADDR'(4);
  assign o_imem_read_addr = pc;
  assign o_imem_read_en   = advance & ~i_reset;
  assign o_halted         = halted;

endmodule
